// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter that time-shares one registered OR/AND/XOR/NOR unit among NREQ requesters.
// Each transaction runs IDLE -> EXEC -> RESP. Grant is held across EXEC and RESP, and done pulses in RESP.
module logic_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ*2-1:0]     op_sel,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic [CNT_W-1:0]      txn_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic [CNT_W-1:0]   txn_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [1:0]         sel_q;

  logic               win_found_s;
  logic [PTR_W-1:0]   win_s;
  logic [WIDTH-1:0]   win_a_s;
  logic [WIDTH-1:0]   win_b_s;
  logic [1:0]         win_sel_s;

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       sel);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b00:   r = a | b;
      2'b01:   r = a & b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a | b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Round-robin pick: first pass takes indices above rr_ptr, second pass wraps to the rest.
  always_comb begin
    logic hit;
    logic above;
    hit         = 1'b0;
    above       = 1'b0;
    win_found_s = 1'b0;
    win_s       = {PTR_W{1'b0}};
    win_a_s     = {WIDTH{1'b0}};
    win_b_s     = {WIDTH{1'b0}};
    win_sel_s   = 2'b00;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < NREQ; j++) begin
        above       = (PTR_W'(j) > rr_ptr_q);
        hit         = !win_found_s && req[j] && ((p == 0) ? above : !above);
        win_s       = hit ? PTR_W'(j) : win_s;
        win_a_s     = hit ? op_a[j*WIDTH +: WIDTH] : win_a_s;
        win_b_s     = hit ? op_b[j*WIDTH +: WIDTH] : win_b_s;
        win_sel_s   = hit ? op_sel[j*2 +: 2] : win_sel_s;
        win_found_s = win_found_s | hit;
      end
    end
  end

  // Transaction sequencer; all outputs are registered here and cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NREQ - 1);
      gnt_q    <= {NREQ{1'b0}};
      done_q   <= {NREQ{1'b0}};
      result_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      txn_q    <= {CNT_W{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      sel_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_s) begin
            gnt_q    <= NREQ'(1) << win_s;
            a_q      <= win_a_s;
            b_q      <= win_b_s;
            sel_q    <= win_sel_s;
            rr_ptr_q <= win_s;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end else begin
            state_q  <= IDLE;
          end
        end
        EXEC: begin
          result_q <= logic_op(a_q, b_q, sel_q);
          done_q   <= gnt_q;
          state_q  <= RESP;
        end
        RESP: begin
          gnt_q   <= {NREQ{1'b0}};
          done_q  <= {NREQ{1'b0}};
          txn_q   <= txn_q + CNT_W'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= {NREQ{1'b0}};
          done_q  <= {NREQ{1'b0}};
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: inputs driven and outputs sampled on the falling edge.
// A second instance with a 4-bit counter shares the stimulus and checks counter wrap.
module tb_logic_op_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  op_a;
  logic [N*W-1:0]  op_b;
  logic [N*2-1:0]  op_sel;
  logic [N-1:0]    gnt, gnt4;
  logic [N-1:0]    done, done4;
  logic [W-1:0]    result, result4;
  logic            busy, busy4;
  logic [15:0]     txn_count;
  logic [3:0]      txn_count4;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  logic_op_arbiter #(.NREQ(N), .WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .txn_count(txn_count)
  );

  logic_op_arbiter #(.NREQ(N), .WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .gnt(gnt4), .done(done4), .result(result4), .busy(busy4), .txn_count(txn_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req    = 4'b0000;
    op_a   = 32'h0;
    op_b   = 32'h0;
    op_sel = 8'h0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b exp=0000", done); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (txn_count !== 16'd0) begin bad++; $display("FAIL reset_txn got=%0d exp=0", txn_count); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    op_a[0 +: 8]  = 8'hA5;
    op_b[0 +: 8]  = 8'h0F;
    op_sel[0 +: 2] = 2'b00;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt_exec got=%b exp=0001", gnt); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_exec got=%b exp=0000", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt_resp got=%b exp=0001", gnt); end
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b exp=0001", done); end
    total++; if (result !== 8'hAF) begin bad++; $display("FAIL single_result got=%h exp=af", result); end
    tick();
    exp_cnt++;
    total++; if ({gnt, done, busy} !== 9'b0) begin bad++; $display("FAIL single_idle got=%b/%b/%b exp=0", gnt, done, busy); end
    total++; if (txn_count !== 16'(exp_cnt)) begin bad++; $display("FAIL single_txn got=%0d exp=%0d", txn_count, exp_cnt); end
  endtask

  task automatic test_ops();
    logic [7:0] exp_r [4];
    exp_r[0] = 8'hEE; exp_r[1] = 8'h88; exp_r[2] = 8'h66; exp_r[3] = 8'h11;
    op_a[16 +: 8] = 8'hCC;
    op_b[16 +: 8] = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      op_sel[4 +: 2] = 2'(i);
      req = 4'b0100;
      tick();
      req = 4'b0000;
      tick();
      total++; if (done !== 4'b0100) begin bad++; $display("FAIL ops_done sel=%0d got=%b exp=0100", i, done); end
      total++; if (result !== exp_r[i]) begin bad++; $display("FAIL ops_result sel=%0d got=%h exp=%h", i, result, exp_r[i]); end
      tick();
      exp_cnt++;
    end
    total++; if (txn_count !== 16'(exp_cnt)) begin bad++; $display("FAIL ops_txn got=%0d exp=%0d", txn_count, exp_cnt); end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_g [6];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001; exp_g[5] = 4'b0010;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (gnt !== exp_g[k]) begin bad++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, exp_g[k]); end
      tick();
      total++; if (done !== exp_g[k]) begin bad++; $display("FAIL rr_done k=%0d got=%b exp=%b", k, done, exp_g[k]); end
      if (k == 5) req = 4'b0000;
      tick();
      exp_cnt++;
      total++; if (txn_count !== 16'(exp_cnt)) begin bad++; $display("FAIL rr_txn k=%0d got=%0d exp=%0d", k, txn_count, exp_cnt); end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rot_first got=%b exp=0010", gnt); end
    tick();
    tick();
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rot_second got=%b exp=0001", gnt); end
    tick();
    tick();
    tick();
    req = 4'b0000;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rot_third got=%b exp=0010", gnt); end
    tick();
    tick();
    exp_cnt = exp_cnt + 3;
  endtask

  task automatic test_no_abort();
    op_a[24 +: 8]  = 8'h3C;
    op_b[24 +: 8]  = 8'h0F;
    op_sel[6 +: 2] = 2'b10;
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL noab_gnt got=%b exp=1000", gnt); end
    req = 4'b0000;
    op_a[24 +: 8]  = 8'hFF;
    op_sel[6 +: 2] = 2'b01;
    tick();
    total++; if (done !== 4'b1000) begin bad++; $display("FAIL noab_done got=%b exp=1000", done); end
    total++; if (result !== 8'h33) begin bad++; $display("FAIL noab_result got=%h exp=33", result); end
    tick();
    exp_cnt++;
    total++; if (txn_count !== 16'(exp_cnt)) begin bad++; $display("FAIL noab_txn got=%0d exp=%0d", txn_count, exp_cnt); end
    total++; if (result !== 8'h33) begin bad++; $display("FAIL noab_hold got=%h exp=33", result); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    op_a[0 +: 8]  = 8'hA5;
    op_b[0 +: 8]  = 8'h0F;
    op_sel[0 +: 2] = 2'b00;
    req = 4'b0001;
    tick();
    tick();
    req = 4'b0000;
    tick();
    total++; if (txn_count !== 16'd1) begin bad++; $display("FAIL rmid_pre_txn got=%0d exp=1", txn_count); end
    req = 4'b0001;
    tick();
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    total++; if ({gnt, done, busy} !== 9'b0) begin bad++; $display("FAIL rmid_async got=%b/%b/%b exp=0", gnt, done, busy); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL rmid_result got=%h exp=00", result); end
    total++; if (txn_count !== 16'd0) begin bad++; $display("FAIL rmid_txn got=%0d exp=0", txn_count); end
    tick();
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL rmid_nodone got=%b exp=0000", done); end
    req = 4'b0110;
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rmid_regrant got=%b exp=0010", gnt); end
    req = 4'b0000;
    tick();
    tick();
    exp_cnt = 1;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0001;
    repeat (51) tick();
    req = 4'b0000;
    total++; if (txn_count4 !== 4'd1) begin bad++; $display("FAIL wrap_cnt4 got=%0d exp=1", txn_count4); end
    total++; if (txn_count !== 16'd17) begin bad++; $display("FAIL wrap_cnt16 got=%0d exp=17", txn_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_rr_all();
    test_rotation();
    test_no_abort();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
